// File: rtl/rx_pkt_drain.sv
// Drains the MAC receive packet interface into a small output FIFO, forwards frames on a
// valid/ready stream and keeps saturating frame statistics. Optional length check: XGE_RX_LEN_CHECK_EN.
module rx_pkt_drain #(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25,
    input  logic        pkt_rx_avail,
    output logic        pkt_rx_ren,
    input  logic [63:0] pkt_rx_data,
    input  logic        pkt_rx_val,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic [2:0]  pkt_rx_mod,
    input  logic        pkt_rx_err,
    output logic [63:0] out_data,
    output logic [2:0]  out_mod,
    output logic        out_val,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_err,
    input  logic        out_rdy,
    input  logic        stat_clr,
    output logic [31:0] stat_frames,
    output logic [31:0] stat_bytes,
    output logic [31:0] stat_err_frames
`ifdef XGE_RX_LEN_CHECK_EN
    ,
    output logic [31:0] stat_len_err
`endif
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (MIN_LEN > MAX_LEN)) begin : g_bad_params
        $error("rx_pkt_drain: illegal parameter set");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, READ = 1'b1} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  mod;
        logic        sop;
        logic        eop;
        logic        err;
    } entry_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // A clear coinciding with an update keeps only the increment.
    function automatic logic [31:0] next_stat(input logic [31:0] cur, input logic [31:0] inc, input logic clr);
        return clr ? inc : sat_add(cur, inc);
    endfunction

    state_t        state_r, state_s;
    logic          ren_s, ren_d1_r, room_s;
    entry_t        mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          in_frame_r, word_s, keep_s, close_s, push_s, pop_s, werr_s;
    logic [15:0]   len_r, base_s, add_s, new_len_s;
    logic [16:0]   sum_s;
    entry_t        entry_s;
    logic          cls_v_r, eop_v_r, eop_err_r;
    logic [15:0]   cls_len_r, eop_len_r;
    logic [31:0]   frm_inc_s, byte_inc_s, err_inc_s;
    logic [31:0]   stat_frames_r, stat_bytes_r, stat_err_frames_r;
`ifdef XGE_RX_LEN_CHECK_EN
    logic          len_bad_s, eop_lbad_r;
    logic [31:0]   stat_len_err_r, lerr_inc_s;
`endif

    // Room counts the word already requested but not yet returned.
    assign room_s = ({1'b0, count_r} + {{CW{1'b0}}, ren_d1_r}) < (CW + 1)'(FIFO_DEPTH);

    // Next-state and read-request decode.
    always_comb begin
        state_s = state_r;
        ren_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pkt_rx_avail) state_s = READ;
                else              state_s = IDLE;
            end
            READ: begin
                ren_s = room_s & ~(pkt_rx_val & pkt_rx_eop);
                if (pkt_rx_val & pkt_rx_eop) state_s = IDLE;
                else                         state_s = READ;
            end
            default: state_s = IDLE;
        endcase
    end

    assign pkt_rx_ren = ren_s;

    // Word qualification and running frame length.
    always_comb begin
        word_s    = (state_r == READ) & pkt_rx_val;
        keep_s    = word_s & (pkt_rx_sop | in_frame_r);
        close_s   = word_s & pkt_rx_sop & in_frame_r;
        base_s    = pkt_rx_sop ? 16'd0 : len_r;
        add_s     = pkt_rx_eop ? ((pkt_rx_mod == 3'd0) ? 16'd8 : {13'd0, pkt_rx_mod}) : 16'd8;
        sum_s     = {1'b0, base_s} + {1'b0, add_s};
        new_len_s = sum_s[16] ? 16'hFFFF : sum_s[15:0];
`ifdef XGE_RX_LEN_CHECK_EN
        len_bad_s = (new_len_s < 16'(MIN_LEN)) || (new_len_s > 16'(MAX_LEN));
        werr_s    = pkt_rx_eop & (pkt_rx_err | len_bad_s);
`else
        werr_s    = pkt_rx_eop & pkt_rx_err;
`endif
        push_s    = keep_s;
        pop_s     = out_val & out_rdy;
        entry_s   = '{data: pkt_rx_data, mod: pkt_rx_mod, sop: pkt_rx_sop, eop: pkt_rx_eop, err: werr_s};
    end

    // FSM state and in-flight read tracking.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state_r  <= IDLE;
            ren_d1_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            ren_d1_r <= ren_s;
        end
    end

    // Output FIFO storage and pointers.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        end
    end

    assign out_data = mem_r[rd_ptr_r].data;
    assign out_mod  = mem_r[rd_ptr_r].mod;
    assign out_sop  = mem_r[rd_ptr_r].sop;
    assign out_eop  = mem_r[rd_ptr_r].eop;
    assign out_err  = mem_r[rd_ptr_r].err;
    assign out_val  = (count_r != '0);

    // Frame tracking; completions are staged one cycle before the counters see them.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            in_frame_r <= 1'b0;
            len_r      <= 16'd0;
            cls_v_r    <= 1'b0;
            cls_len_r  <= 16'd0;
            eop_v_r    <= 1'b0;
            eop_len_r  <= 16'd0;
            eop_err_r  <= 1'b0;
`ifdef XGE_RX_LEN_CHECK_EN
            eop_lbad_r <= 1'b0;
`endif
        end else begin
            if (keep_s) begin
                in_frame_r <= ~pkt_rx_eop;
                len_r      <= pkt_rx_eop ? 16'd0 : new_len_s;
            end
            cls_v_r   <= close_s;
            cls_len_r <= len_r;
            eop_v_r   <= keep_s & pkt_rx_eop;
            eop_len_r <= new_len_s;
            eop_err_r <= werr_s;
`ifdef XGE_RX_LEN_CHECK_EN
            eop_lbad_r <= len_bad_s;
`endif
        end
    end

    // A sop that cuts a frame short closes it as an errored frame alongside any normal eop.
    assign frm_inc_s  = {31'd0, cls_v_r} + {31'd0, eop_v_r};
    assign byte_inc_s = (cls_v_r ? {16'd0, cls_len_r} : 32'd0) + (eop_v_r ? {16'd0, eop_len_r} : 32'd0);
    assign err_inc_s  = {31'd0, cls_v_r} + {31'd0, eop_v_r & eop_err_r};
`ifdef XGE_RX_LEN_CHECK_EN
    assign lerr_inc_s = {31'd0, eop_v_r & eop_lbad_r};
`endif

    // Saturating statistics counters.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            stat_frames_r     <= 32'd0;
            stat_bytes_r      <= 32'd0;
            stat_err_frames_r <= 32'd0;
`ifdef XGE_RX_LEN_CHECK_EN
            stat_len_err_r    <= 32'd0;
`endif
        end else begin
            stat_frames_r     <= next_stat(stat_frames_r, frm_inc_s, stat_clr);
            stat_bytes_r      <= next_stat(stat_bytes_r, byte_inc_s, stat_clr);
            stat_err_frames_r <= next_stat(stat_err_frames_r, err_inc_s, stat_clr);
`ifdef XGE_RX_LEN_CHECK_EN
            stat_len_err_r    <= next_stat(stat_len_err_r, lerr_inc_s, stat_clr);
`endif
        end
    end

    assign stat_frames     = stat_frames_r;
    assign stat_bytes      = stat_bytes_r;
    assign stat_err_frames = stat_err_frames_r;
`ifdef XGE_RX_LEN_CHECK_EN
    assign stat_len_err    = stat_len_err_r;
`endif

endmodule

// File: tb/tb_rx_pkt_drain.sv
// Directed bench for rx_pkt_drain: behavioural MAC packet-side model, output capture,
// table of frames plus hand sequences for backpressure, reset mid-frame and counter saturation.
module tb_rx_pkt_drain;

    logic        clk = 1'b0;
    logic        reset, pkt_rx_avail, pkt_rx_ren, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
    logic [63:0] pkt_rx_data, out_data;
    logic [2:0]  pkt_rx_mod, out_mod;
    logic        out_val, out_sop, out_eop, out_err, out_rdy, stat_clr;
    logic [31:0] stat_frames, stat_bytes, stat_err_frames;
`ifdef XGE_RX_LEN_CHECK_EN
    logic [31:0] stat_len_err;
`endif

    always #5 clk = ~clk;

    rx_pkt_drain dut (
        .clk_156m25(clk), .reset_156m25(reset), .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren),
        .pkt_rx_data(pkt_rx_data), .pkt_rx_val(pkt_rx_val), .pkt_rx_sop(pkt_rx_sop),
        .pkt_rx_eop(pkt_rx_eop), .pkt_rx_mod(pkt_rx_mod), .pkt_rx_err(pkt_rx_err),
        .out_data(out_data), .out_mod(out_mod), .out_val(out_val), .out_sop(out_sop),
        .out_eop(out_eop), .out_err(out_err), .out_rdy(out_rdy), .stat_clr(stat_clr),
        .stat_frames(stat_frames), .stat_bytes(stat_bytes), .stat_err_frames(stat_err_frames)
`ifdef XGE_RX_LEN_CHECK_EN
        , .stat_len_err(stat_len_err)
`endif
    );

    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } word_t;

    typedef struct {
        int         nwords;
        logic [2:0] mod;
        logic       err;
        int         exp_len;
    } vec_t;

    word_t       macq[$];
    word_t       capq[$];
    int          mac_sent = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_frames = 32'd0, exp_bytes = 32'd0, exp_errf = 32'd0, exp_lerr = 32'd0;

    function automatic word_t mk_word(int f, int i, int n, logic [2:0] mod, logic err);
        word_t w;
        w.d   = {16'hA5A5, f[15:0], i[31:0]};
        w.sop = (i == 0);
        w.eop = (i == n - 1);
        w.mod = w.eop ? mod : 3'd0;
        w.err = w.eop ? err : 1'b0;
        return w;
    endfunction

    function automatic logic lc_bad(int len);
`ifdef XGE_RX_LEN_CHECK_EN
        return (len < 64) || (len > 1518);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] a, int b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // MAC model: each request seen in a cycle returns one word in the next cycle.
    initial begin
        logic  r;
        word_t w;
        pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0; pkt_rx_mod = 3'd0;
        pkt_rx_err = 1'b0; pkt_rx_data = 64'd0; pkt_rx_avail = 1'b0;
        forever begin
            @(negedge clk);
            r = pkt_rx_ren;
            @(posedge clk);
            #1;
            if (r && macq.size() > 0) begin
                w = macq.pop_front();
                pkt_rx_val = 1'b1; pkt_rx_data = w.d; pkt_rx_sop = w.sop;
                pkt_rx_eop = w.eop; pkt_rx_mod = w.mod; pkt_rx_err = w.err;
                mac_sent++;
            end else begin
                pkt_rx_val = 1'b0; pkt_rx_data = 64'd0; pkt_rx_sop = 1'b0;
                pkt_rx_eop = 1'b0; pkt_rx_mod = 3'd0; pkt_rx_err = 1'b0;
            end
            pkt_rx_avail = (macq.size() != 0);
        end
    end

    // Capture every accepted output word.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_val && out_rdy)
                capq.push_back('{d: out_data, sop: out_sop, eop: out_eop, mod: out_mod, err: out_err});
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic queue_frame(int f, int n, logic [2:0] mod, logic err);
        for (int i = 0; i < n; i++) macq.push_back(mk_word(f, i, n, mod, err));
    endtask

    task automatic wait_idle(string name);
        int quiet = 0;
        int cyc = 0;
        while (quiet < 4 && cyc < 3000) begin
            step();
            cyc++;
            if (macq.size() == 0 && !pkt_rx_val && !out_val && !pkt_rx_ren) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_%s: got busy expected idle", name);
        end
    endtask

    task automatic check_frame(int f, int n, logic [2:0] mod, logic err);
        int bad = 0;
        word_t e;
        chk($sformatf("frame%0d_words", f), 64'(capq.size()), 64'(n));
        if (capq.size() == n) begin
            for (int i = 0; i < n; i++) begin
                e = mk_word(f, i, n, mod, err);
                if (capq[i] !== e) begin
                    if (bad == 0) $display("FAIL frame%0d_word%0d: got %h expected %h", f, i, capq[i], e);
                    bad++;
                end
            end
            chk($sformatf("frame%0d_content", f), 64'(bad), 64'd0);
        end
        capq.delete();
    endtask

    task automatic check_stats(string name);
        chk({name, "_frames"}, 64'(stat_frames), 64'(exp_frames));
        chk({name, "_bytes"}, 64'(stat_bytes), 64'(exp_bytes));
        chk({name, "_errf"}, 64'(stat_err_frames), 64'(exp_errf));
`ifdef XGE_RX_LEN_CHECK_EN
        chk({name, "_lenerr"}, 64'(stat_len_err), 64'(exp_lerr));
`endif
    endtask

    task automatic run_frame(int f, int n, logic [2:0] mod, logic err, int len);
        logic bad;
        bad = lc_bad(len);
        queue_frame(f, n, mod, err);
        step();
        chk($sformatf("frame%0d_ren_idle", f), 64'(pkt_rx_ren), 64'd0);
        step();
        chk($sformatf("frame%0d_ren_read", f), 64'(pkt_rx_ren), 64'd1);
        wait_idle($sformatf("frame%0d", f));
        check_frame(f, n, mod, err | bad);
        exp_frames = sat_inc(exp_frames, 1);
        exp_bytes  = sat_inc(exp_bytes, len);
        exp_errf   = sat_inc(exp_errf, (err | bad) ? 1 : 0);
        exp_lerr   = sat_inc(exp_lerr, bad ? 1 : 0);
        check_stats($sformatf("frame%0d", f));
    endtask

    initial begin
        vec_t vecs[5];
        int   s0;
        logic found;

        vecs[0] = '{nwords: 8, mod: 3'd4, err: 1'b0, exp_len: 60};
        vecs[1] = '{nwords: 1, mod: 3'd0, err: 1'b0, exp_len: 8};
        vecs[2] = '{nwords: 3, mod: 3'd1, err: 1'b0, exp_len: 17};
        vecs[3] = '{nwords: 2, mod: 3'd7, err: 1'b1, exp_len: 15};
        vecs[4] = '{nwords: 8, mod: 3'd0, err: 1'b0, exp_len: 64};

        reset = 1'b1; out_rdy = 1'b1; stat_clr = 1'b0;
        repeat (3) step();
        chk("reset_ren", 64'(pkt_rx_ren), 64'd0);
        chk("reset_out_val", 64'(out_val), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_out_flags", 64'({out_sop, out_eop, out_err, out_mod}), 64'd0);
        check_stats("reset");
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++)
            run_frame(i + 1, vecs[i].nwords, vecs[i].mod, vecs[i].err, vecs[i].exp_len);

        // Backpressure: the FIFO fills to its depth and reads stop.
        out_rdy = 1'b0;
        s0 = mac_sent;
        queue_frame(50, 8, 3'd4, 1'b0);
        repeat (20) step();
        chk("bp_words_read", 64'(mac_sent - s0), 64'd4);
        chk("bp_ren_low", 64'(pkt_rx_ren), 64'd0);
        chk("bp_out_val", 64'(out_val), 64'd1);
        chk("bp_nothing_out", 64'(capq.size()), 64'd0);
        out_rdy = 1'b1;
        wait_idle("bp");
        check_frame(50, 8, 3'd4, 1'b0);
        exp_frames = sat_inc(exp_frames, 1);
        exp_bytes  = sat_inc(exp_bytes, 60);
        check_stats("bp");

        // Reset after three words of a frame; its tail must be discarded.
        s0 = mac_sent;
        queue_frame(100, 8, 3'd0, 1'b0);
        queue_frame(101, 3, 3'd2, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            step();
            if (mac_sent - s0 >= 3) found = 1'b1;
        end
        chk("rst_mid_reached", 64'(found), 64'd1);
        reset = 1'b1;
        step();
        step();
        chk("rst_mid_out_val", 64'(out_val), 64'd0);
        chk("rst_mid_stats", 64'(stat_frames), 64'd0);
        reset = 1'b0;
        capq.delete();
        wait_idle("rst_mid");
        check_frame(101, 3, 3'd2, lc_bad(18));
        exp_frames = 32'd1;
        exp_bytes  = 32'd18;
        exp_errf   = lc_bad(18) ? 32'd1 : 32'd0;
        exp_lerr   = lc_bad(18) ? 32'd1 : 32'd0;
        check_stats("rst_mid");

        // Frame counter saturation.
        force dut.stat_frames_r = 32'hFFFF_FFFE;
        step();
        release dut.stat_frames_r;
        step();
        chk("sat_preload", 64'(stat_frames), 64'hFFFF_FFFE);
        exp_frames = 32'hFFFF_FFFE;
        run_frame(200, 1, 3'd0, 1'b0, 8);
        run_frame(201, 1, 3'd0, 1'b0, 8);
        chk("sat_hold", 64'(stat_frames), 64'hFFFF_FFFF);

        // Clear on the same cycle as an update keeps just that frame.
        queue_frame(300, 3, 3'd2, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            if (pkt_rx_val && pkt_rx_eop) found = 1'b1;
        end
        chk("clr_eop_seen", 64'(found), 64'd1);
        step();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        wait_idle("clr");
        check_frame(300, 3, 3'd2, lc_bad(18));
        exp_frames = 32'd1;
        exp_bytes  = 32'd18;
        exp_errf   = lc_bad(18) ? 32'd1 : 32'd0;
        exp_lerr   = lc_bad(18) ? 32'd1 : 32'd0;
        check_stats("clr");

`ifdef XGE_RX_LEN_CHECK_EN
        s0 = int'(stat_len_err);
        run_frame(400, 5, 3'd0, 1'b0, 40);
        run_frame(401, 200, 3'd0, 1'b0, 1600);
        run_frame(402, 8, 3'd0, 1'b0, 64);
        chk("lenchk_delta", 64'(int'(stat_len_err) - s0), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
